// File: rtl/multichannel_sample_serializer.sv
// Per-channel sample FIFOs feeding MSB-first shift registers, one serial line per channel.
// Each channel loads its next sample back-to-back with the previous one, so no gap bit appears.
module multichannel_sample_serializer #(
    parameter int NUM_CHANNELS = 7,
    parameter int SAMPLE_BITS  = 8,
    parameter int FIFO_DEPTH   = 4,
    localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ena,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CH_W-1:0]         wr_channel,
    input  logic [SAMPLE_BITS-1:0]  wr_data,
    output logic [NUM_CHANNELS-1:0] ser_out,
    output logic [NUM_CHANNELS-1:0] ser_frame,
    output logic [NUM_CHANNELS-1:0] ser_active,
    output logic [NUM_CHANNELS-1:0] fifo_empty,
    output logic [NUM_CHANNELS-1:0] drained,
    input  logic                    clear_drained
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(SAMPLE_BITS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [NUM_CHANNELS-1:0] w_sel;
    logic [NUM_CHANNELS-1:0] w_full;

    // Out-of-range channel indices select no channel, so they are never accepted.
    assign wr_ready = ena && |(w_sel & ~w_full);

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [SAMPLE_BITS-1:0] r_mem [FIFO_DEPTH];
            logic [PTR_W-1:0]       r_wr_ptr;
            logic [PTR_W-1:0]       r_rd_ptr;
            logic [SAMPLE_BITS-1:0] r_shift;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_ser;
            logic                   r_frame;
            logic                   r_active;
            logic                   r_drained;
            state_t                 r_state;
            state_t                 w_state_next;
            logic [SAMPLE_BITS-1:0] w_head;
            logic                   w_empty;
            logic                   w_wr_en;
            logic                   w_load;
            logic                   w_shift;
            logic                   w_finish;

            assign w_sel[gi]  = (wr_channel == CH_W'(gi));
            assign w_empty    = (r_wr_ptr == r_rd_ptr);
            assign w_full[gi] = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                                (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);
            assign w_wr_en    = wr_valid && wr_ready && w_sel[gi];
            assign w_head     = r_mem[r_rd_ptr[ADDR_W-1:0]];

            always_comb begin
                w_state_next = r_state;
                w_load       = 1'b0;
                w_shift      = 1'b0;
                w_finish     = 1'b0;
                if (ena) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (!w_empty) begin
                                w_load       = 1'b1;
                                w_state_next = ST_SHIFT;
                            end
                        end
                        ST_SHIFT: begin
                            if (r_cnt != '0) begin
                                w_shift = 1'b1;
                            end else if (!w_empty) begin
                                w_load = 1'b1;
                            end else begin
                                w_finish     = 1'b1;
                                w_state_next = ST_IDLE;
                            end
                        end
                        default: w_state_next = ST_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state <= w_state_next;
                end
            end

            always_ff @(posedge clk) begin
                if (w_wr_en) begin
                    r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
                end
            end

            // r_shift holds the not-yet-sent bits left-aligned; the MSB goes straight to the line.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_shift  <= '0;
                    r_cnt    <= '0;
                    r_ser    <= 1'b0;
                    r_frame  <= 1'b0;
                    r_active <= 1'b0;
                end else begin
                    if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                    if (w_load) begin
                        r_shift  <= {w_head[SAMPLE_BITS-2:0], 1'b0};
                        r_ser    <= w_head[SAMPLE_BITS-1];
                        r_cnt    <= CNT_W'(SAMPLE_BITS - 1);
                        r_frame  <= 1'b1;
                        r_active <= 1'b1;
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    end else if (w_shift) begin
                        r_shift  <= {r_shift[SAMPLE_BITS-2:0], 1'b0};
                        r_ser    <= r_shift[SAMPLE_BITS-1];
                        r_cnt    <= r_cnt - CNT_W'(1);
                        r_frame  <= 1'b0;
                    end else if (ena) begin
                        r_ser    <= 1'b0;
                        r_frame  <= 1'b0;
                        r_active <= 1'b0;
                    end
                end
            end

            // Set wins over a coincident clear; clearing also works while frozen.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_drained <= 1'b0;
                end else if (w_finish) begin
                    r_drained <= 1'b1;
                end else if (clear_drained) begin
                    r_drained <= 1'b0;
                end
            end

            assign ser_out[gi]    = r_ser;
            assign ser_frame[gi]  = r_frame;
            assign ser_active[gi] = r_active;
            assign fifo_empty[gi] = w_empty;
            assign drained[gi]    = r_drained;
        end
    endgenerate

endmodule
